// File: rtl/strap_seq_ctrl.sv
// Pad strap sampler with stability filter/timeout fallback, sticky strap register and soft-reboot pulse sequencer.
// Straps accepted STABLE_CNT cycles after reset when stable (TIMEOUT cycles worst case); register writes take effect next cycle.
// No backpressure: register writes are dropped outside RUN, and while soft reset or a reboot pulse is active.
module strap_seq_ctrl #(
  parameter int unsigned          PSTRAP_W       = 8,
  parameter logic [PSTRAP_W-1:0]  PSTRAP_DEFAULT = 8'h74,
  parameter int unsigned          STICKY_W       = 32,
  parameter int unsigned          STABLE_CNT     = 4,
  parameter int unsigned          TIMEOUT        = 64,
  parameter int unsigned          REBOOT_BIT     = 31,
  parameter int unsigned          REBOOT_PULSE   = 16
) (
  input  logic                  clk,
  input  logic                  e_reset_n,
  input  logic                  p_reset_n,
  input  logic                  s_reset_n,
  input  logic [PSTRAP_W-1:0]   pad_strap_in,
  input  logic                  cs,
  input  logic [STICKY_W/8-1:0] we,
  input  logic [STICKY_W-1:0]   data_in,
  input  logic [STICKY_W-1:0]   strap_map,
  output logic [PSTRAP_W-1:0]   strap_latch,
  output logic [PSTRAP_W-1:0]   pstrap_select,
  output logic                  strap_valid,
  output logic                  strap_timeout,
  output logic [STICKY_W-1:0]   strap_sticky,
  output logic                  reboot_req
);

  localparam int NB      = STICKY_W / 8;
  localparam int RB_BYTE = REBOOT_BIT / 8;
  localparam int SC_W    = $clog2(STABLE_CNT) + 1;
  localparam int TO_W    = $clog2(TIMEOUT) + 1;
  localparam int RP_W    = $clog2(REBOOT_PULSE) + 1;

  // stab_cnt counts matches against the previous sample, so N identical
  // samples correspond to a count of N-1 reached on the accepting cycle.
  localparam logic [SC_W-1:0] STAB_LAST = SC_W'(STABLE_CNT - 2);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [RP_W-1:0] RP_LOAD   = RP_W'(REBOOT_PULSE - 1);

  typedef enum logic [1:0] {
    ST_SAMPLE,
    ST_LOAD,
    ST_RUN,
    ST_REBOOT
  } state_t;

  state_t                state_q, state_d;
  logic [PSTRAP_W-1:0]   prev_q;
  logic                  prev_vld_q;
  logic [SC_W-1:0]       stab_cnt_q;
  logic [TO_W-1:0]       samp_cnt_q;
  logic [RP_W-1:0]       pulse_cnt_q;
  logic [PSTRAP_W-1:0]   latch_q;
  logic                  valid_q;
  logic                  timeout_q;
  logic [STICKY_W-1:0]   sticky_q;
  logic                  req_q;

  logic same_smp;
  logic accept;
  logic tmo_hit;
  logic wr_reboot;
  logic pulse_done;

  // The first sample after reset has no predecessor and can never count as a match.
  assign same_smp   = prev_vld_q && (pad_strap_in == prev_q);
  assign accept     = same_smp && (stab_cnt_q == STAB_LAST);
  assign tmo_hit    = (samp_cnt_q == TO_LAST);
  assign wr_reboot  = cs && we[RB_BYTE] && data_in[REBOOT_BIT];
  assign pulse_done = (pulse_cnt_q == '0);

  // State register
  always_ff @(posedge clk or negedge e_reset_n) begin
    if (!e_reset_n) state_q <= ST_SAMPLE;
    else            state_q <= state_d;
  end

  // Next-state logic; power-on reset dominates soft reset and writes
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SAMPLE: if (accept || tmo_hit) state_d = ST_LOAD;
      ST_LOAD:   if (p_reset_n) state_d = ST_RUN;
      ST_RUN: begin
        if (!p_reset_n)                   state_d = ST_LOAD;
        else if (s_reset_n && wr_reboot)  state_d = ST_REBOOT;
      end
      ST_REBOOT: begin
        if (!p_reset_n)      state_d = ST_LOAD;
        else if (pulse_done) state_d = ST_RUN;
      end
      default: state_d = ST_SAMPLE;
    endcase
  end

  // Strap sampler: stability filter, timeout fallback, latched result frozen after SAMPLE
  always_ff @(posedge clk or negedge e_reset_n) begin
    if (!e_reset_n) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      stab_cnt_q <= '0;
      samp_cnt_q <= '0;
      latch_q    <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else if (state_q == ST_SAMPLE) begin
      prev_q     <= pad_strap_in;
      prev_vld_q <= 1'b1;
      stab_cnt_q <= same_smp ? stab_cnt_q + SC_W'(1) : '0;
      samp_cnt_q <= samp_cnt_q + TO_W'(1);
      if (accept) begin
        latch_q <= pad_strap_in;
        valid_q <= 1'b1;
      end else if (tmo_hit) begin
        latch_q   <= PSTRAP_DEFAULT;
        timeout_q <= 1'b1;
        valid_q   <= 1'b1;
      end
    end
  end

  // Sticky register, byte writes and reboot pulse timing
  always_ff @(posedge clk or negedge e_reset_n) begin
    if (!e_reset_n) begin
      sticky_q    <= '0;
      req_q       <= 1'b0;
      pulse_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_LOAD: sticky_q <= strap_map;
        ST_RUN: begin
          if (!p_reset_n) begin
            sticky_q <= sticky_q;
          end else if (!s_reset_n) begin
            sticky_q[REBOOT_BIT] <= 1'b0;
          end else begin
            for (int i = 0; i < NB; i++) begin
              if (cs && we[i]) sticky_q[8*i +: 8] <= data_in[8*i +: 8];
            end
            if (wr_reboot) begin
              req_q       <= 1'b1;
              pulse_cnt_q <= RP_LOAD;
            end
          end
        end
        ST_REBOOT: begin
          if (!p_reset_n) begin
            req_q <= 1'b0;
          end else if (pulse_done) begin
            req_q                <= 1'b0;
            sticky_q[REBOOT_BIT] <= 1'b0;
          end else begin
            pulse_cnt_q <= pulse_cnt_q - RP_W'(1);
          end
        end
        default: sticky_q <= sticky_q;
      endcase
    end
  end

  assign strap_latch   = latch_q;
  assign pstrap_select = latch_q[PSTRAP_W-1] ? PSTRAP_DEFAULT : latch_q;
  assign strap_valid   = valid_q;
  assign strap_timeout = timeout_q;
  assign strap_sticky  = sticky_q;
  assign reboot_req    = req_q;

endmodule

// File: tb/tb_strap_seq_ctrl.sv
// Directed-plus-random bench for strap_seq_ctrl with a spec-level reference model.
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
// Every wait is a bounded loop, so the run always reaches its summary line.
module tb_strap_seq_ctrl;

  localparam int         STABLE = 4;
  localparam int         TMO    = 64;
  localparam int         RBIT   = 31;
  localparam int         RPULSE = 16;
  localparam logic [7:0] DEF    = 8'h74;

  logic        clk = 1'b0;
  logic        e_reset_n, p_reset_n, s_reset_n, cs;
  logic [7:0]  pad;
  logic [3:0]  we;
  logic [31:0] data_in, strap_map;
  logic [7:0]  strap_latch, pstrap_select;
  logic        strap_valid, strap_timeout, reboot_req;
  logic [31:0] strap_sticky;

  always #5 clk = ~clk;

  strap_seq_ctrl dut (
    .clk           (clk),
    .e_reset_n     (e_reset_n),
    .p_reset_n     (p_reset_n),
    .s_reset_n     (s_reset_n),
    .pad_strap_in  (pad),
    .cs            (cs),
    .we            (we),
    .data_in       (data_in),
    .strap_map     (strap_map),
    .strap_latch   (strap_latch),
    .pstrap_select (pstrap_select),
    .strap_valid   (strap_valid),
    .strap_timeout (strap_timeout),
    .strap_sticky  (strap_sticky),
    .reboot_req    (reboot_req)
  );

  // External strap map: an arbitrary but distinctive function of the selected straps.
  function automatic logic [31:0] fmap(input logic [7:0] s);
    return {~s, s ^ 8'h3C, s, ~s};
  endfunction

  assign strap_map = fmap(pstrap_select);

  function automatic logic [7:0] sel_of(input logic [7:0] l);
    return l[7] ? DEF : l;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] w,
                                        input logic [31:0] d);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (w[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  int          n_vec = 0;
  int          n_miss = 0;
  logic [7:0]  m_latch, m_sel;
  logic [31:0] m_sticky;
  logic [7:0]  pad_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    e_reset_n = 1'b0; p_reset_n = 1'b0; s_reset_n = 1'b1;
    cs = 1'b0; we = 4'h0; data_in = '0; pad = '0;
    step;
    chk("rst_latch",   32'(strap_latch),   32'h0);
    chk("rst_valid",   32'(strap_valid),   32'h0);
    chk("rst_timeout", 32'(strap_timeout), 32'h0);
    chk("rst_sticky",  strap_sticky,       32'h0);
    chk("rst_req",     32'(reboot_req),    32'h0);
    e_reset_n = 1'b1;
  endtask

  // Applies pad_q (one entry per sample cycle), then holds power-on reset for
  // hold cycles and releases it, leaving the DUT in RUN with m_sticky loaded.
  task automatic run_sample(input int hold);
    int         acc_n;
    logic [7:0] exp_l;
    logic       exp_t;
    acc_n = TMO; exp_l = DEF; exp_t = 1'b1;
    for (int n = STABLE; n <= TMO; n++) begin
      bit same;
      same = 1'b1;
      for (int k = n - STABLE; k < n; k++) if (pad_q[k] !== pad_q[n-1]) same = 1'b0;
      if (same) begin
        acc_n = n; exp_l = pad_q[n-1]; exp_t = 1'b0;
        break;
      end
    end
    for (int n = 1; n <= acc_n; n++) begin
      pad = pad_q[n-1]; cs = 1'b1; we = 4'hF; data_in = $urandom;
      step;
      chk("smp_valid", 32'(strap_valid), 32'(n == acc_n));
    end
    m_latch = exp_l;
    m_sel   = sel_of(exp_l);
    chk("smp_latch",   32'(strap_latch),   32'(m_latch));
    chk("smp_timeout", 32'(strap_timeout), 32'(exp_t));
    chk("smp_select",  32'(pstrap_select), 32'(m_sel));
    chk("smp_sticky",  strap_sticky,       32'h0);
    for (int c = 0; c < hold; c++) begin
      pad = 8'($urandom);
      step;
      chk("load_sticky", strap_sticky, fmap(m_sel));
    end
    cs = 1'b0;
    p_reset_n = 1'b1;
    step;
    m_sticky = fmap(m_sel);
    chk("load_final", strap_sticky, m_sticky);
    chk("load_latch", 32'(strap_latch), 32'(m_latch));
  endtask

  task automatic wr(input logic c, input logic [3:0] w, input logic [31:0] d);
    cs = c; we = w; data_in = d;
    step;
    if (c && s_reset_n) m_sticky = merge(m_sticky, w, d);
    cs = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    int         run;

    // Stable straps with a long power-on reset
    do_reset;
    pad_q.delete();
    for (int i = 0; i < TMO; i++) pad_q.push_back(8'h25);
    run_sample(20);

    // Soft reset clears only the reboot bit (set by the strap map) and drops the write
    s_reset_n = 1'b0; cs = 1'b1; we = 4'hF; data_in = $urandom;
    step;
    m_sticky[RBIT] = 1'b0;
    chk("srst_sticky", strap_sticky, m_sticky);
    s_reset_n = 1'b1; cs = 1'b0;

    // Byte enables
    wr(1'b1, 4'hF, 32'h0);
    chk("be_clear", strap_sticky, 32'h0);
    wr(1'b1, 4'b0101, 32'h1122_3344);
    chk("be_0101", strap_sticky, 32'h0022_0044);

    // Random non-reboot writes
    for (int i = 0; i < 12; i++) begin
      wr(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), $urandom & 32'h7FFF_FFFF);
      chk("rand_wr", strap_sticky, m_sticky);
    end

    // Full reboot pulse; writes and soft reset during the pulse have no effect
    wr(1'b1, 4'b1000, 32'h8000_0000);
    chk("rb_req_k1", 32'(reboot_req), 32'h1);
    chk("rb_sticky", strap_sticky, m_sticky);
    for (int k = 2; k <= RPULSE; k++) begin
      cs = 1'b1; we = 4'($urandom_range(0, 15)); data_in = $urandom;
      s_reset_n = 1'($urandom_range(0, 1));
      step;
      chk("rb_req_hi", 32'(reboot_req), 32'h1);
      chk("rb_hold",   strap_sticky,    m_sticky);
    end
    cs = 1'b0; s_reset_n = 1'b1;
    step;
    m_sticky[RBIT] = 1'b0;
    chk("rb_req_end", 32'(reboot_req), 32'h0);
    chk("rb_bit_clr", strap_sticky,    m_sticky);
    wr(1'b1, 4'b0001, 32'h0000_005A);
    chk("rb_back_run", strap_sticky, m_sticky);

    // Power-on reset aborts a pulse in its fifth cycle; no strap resample
    wr(1'b1, 4'b1000, 32'h8000_0000);
    for (int k = 2; k <= 5; k++) begin
      step;
      chk("ab_req_hi", 32'(reboot_req), 32'h1);
    end
    p_reset_n = 1'b0;
    step;
    chk("ab_req_lo", 32'(reboot_req), 32'h0);
    for (int c = 0; c < 3; c++) begin
      pad = 8'($urandom);
      step;
      chk("ab_sticky", strap_sticky,       fmap(m_sel));
      chk("ab_latch",  32'(strap_latch),   32'(m_latch));
      chk("ab_req",    32'(reboot_req),    32'h0);
    end
    p_reset_n = 1'b1;
    step;
    m_sticky = fmap(m_sel);
    chk("ab_reload", strap_sticky, m_sticky);
    wr(1'b1, 4'b0010, 32'h0000_A500);
    chk("ab_run_wr", strap_sticky, m_sticky);

    // External reset in the middle of a pulse takes effect immediately
    wr(1'b1, 4'b1000, 32'h8000_0000);
    step;
    chk("er_req_pre", 32'(reboot_req), 32'h1);
    #3;
    e_reset_n = 1'b0;
    #1;
    chk("er_req",    32'(reboot_req),  32'h0);
    chk("er_sticky", strap_sticky,     32'h0);
    chk("er_valid",  32'(strap_valid), 32'h0);
    chk("er_latch",  32'(strap_latch), 32'h0);

    // Default mode strap
    do_reset;
    pad_q.delete();
    for (int i = 0; i < TMO; i++) pad_q.push_back(8'hA5);
    run_sample(3);

    // Toggling pads time out
    do_reset;
    pad_q.delete();
    for (int i = 0; i < TMO; i++) pad_q.push_back(i[0] ? 8'hC3 : 8'h3C);
    run_sample(3);

    // Acceptance on the timeout cycle wins
    do_reset;
    pad_q.delete();
    for (int i = 0; i < TMO - STABLE; i++) pad_q.push_back(i[0] ? 8'hC3 : 8'h3C);
    for (int i = 0; i < STABLE; i++) pad_q.push_back(8'h9E);
    run_sample(2);

    // Random run-length strap patterns
    for (int t = 0; t < 5; t++) begin
      do_reset;
      pad_q.delete();
      v = 8'($urandom);
      while (pad_q.size() < TMO) begin
        run = $urandom_range(1, STABLE + (t == 0 ? 0 : 0));
        if (t < 2 && run == STABLE) run = STABLE - 1;
        v = v ^ 8'($urandom_range(1, 255));
        for (int r = 0; r < run; r++) if (pad_q.size() < TMO) pad_q.push_back(v);
      end
      run_sample(2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
